// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment driver.
//   SEG_0..SEG_9, SEG_BLANK : segment patterns {a,b,c,d,e,f,g}, MSB = a, 1 = lit
//   bcd_to_seg()            : BCD digit -> segment pattern (10..15 decode blank)
//   pol()                   : applies board polarity (inverts when active_low)
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // 8 bits wide so it serves both the 7-bit segment bus and up to 8 digit selects.
    function automatic logic [7:0] pol(input logic [7:0] v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundle between the BCD producer and the scan driver.
//   bcd_in[4*NUM_DIGITS] : digit i at [4i+3:4i], digit 0 rightmost
//   load                 : capture bcd_in into the driver's shadow copy
//   blank_lz             : enable leading-zero blanking
//   blink_mask[NUM_DIGITS]: per-digit blink enable
//   seg_out[7]           : shared segment bus {a..g}, polarity adjusted
//   dig_sel[NUM_DIGITS]  : one-hot digit enable, polarity adjusted
//   frame_done           : one-cycle pulse per completed scan frame
// master = producer side, slave = driver side.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output bcd_in, load, blank_lz, blink_mask,
        input  seg_out, dig_sel, frame_done
    );

    modport slave (
        input  bcd_in, load, blank_lz, blink_mask,
        output seg_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg7_lz_blank.sv
// -----------------------------------------------------------------------------
// seg7_lz_blank
// Combinational leading-zero detector.
//   digits[4*NUM_DIGITS] : shadow BCD digits, digit 0 least significant
//   blank_lz             : enable
//   lz_blank[NUM_DIGITS] : bit i = 1 when digit i and everything above it is 0;
//                          digit 0 is never blanked so a zero value still shows "0"
// -----------------------------------------------------------------------------
module seg7_lz_blank #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   lz_blank
);
    logic seen_nonzero;

    // Prefix-OR walking down from the most significant digit.
    always_comb begin
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nonzero = seen_nonzero | (digits[4*i +: 4] != 4'd0);
            lz_blank[i]  = blank_lz & ~seen_nonzero & (i != 0);
        end
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed N-digit 7-segment driver with leading-zero blanking,
// per-digit blink, output polarity select and a dead cycle at the start of
// every digit slot to suppress ghosting.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seg7_scan_driver_if.slave (bcd_in/load/blank_lz/blink_mask in,
//              seg_out/dig_sel/frame_done out, all outputs registered)
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 250,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int IDW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCW-1:0]        SC_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [IDW-1:0]        IDX_LAST = IDW'(NUM_DIGITS - 1);
    localparam logic [FCW-1:0]        FC_LAST  = FCW'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SEG_OFF  = 7'(pol(8'h00, ACTIVE_LOW));
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = NUM_DIGITS'(pol(8'h00, ACTIVE_LOW));

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [SCW-1:0]          scan_cnt;
    logic [IDW-1:0]          idx;
    logic [FCW-1:0]          frame_cnt;
    logic                    blink_phase;

    logic [6:0]              seg_p1;
    logic [NUM_DIGITS-1:0]   dig_sel_p1;
    logic                    frame_done_p1;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_digit;
    logic                    cur_blank;
    logic [6:0]              cur_pattern;
    logic [NUM_DIGITS-1:0]   cur_onehot;

    seg7_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz_blank (
        .digits   (shadow),
        .blank_lz (bus.blank_lz),
        .lz_blank (lz_blank)
    );

    // ---- stage p0: scan position and pattern of the digit currently scanned ----
    assign slot_end    = (scan_cnt == SC_LAST);
    assign frame_end   = slot_end && (idx == IDX_LAST);
    assign cur_digit   = shadow[{idx, 2'b00} +: 4];
    assign cur_blank   = lz_blank[idx] | (bus.blink_mask[idx] & blink_phase);
    assign cur_pattern = cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
    assign cur_onehot  = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= '0;
            scan_cnt      <= '0;
            idx           <= '0;
            frame_cnt     <= '0;
            blink_phase   <= 1'b0;
            frame_done_p1 <= 1'b0;
            seg_p1        <= SEG_OFF;
            dig_sel_p1    <= DIG_OFF;
        end else begin
            if (bus.load) begin
                shadow <= bus.bcd_in;
            end

            if (slot_end) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (frame_end) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // ---- stage p1: registered pin drivers ----
            frame_done_p1 <= frame_end;
            seg_p1        <= 7'(pol({1'b0, cur_pattern}, ACTIVE_LOW));
            // scan_cnt == 0 is the first cycle of a slot: keep every digit off.
            dig_sel_p1    <= (scan_cnt == '0) ? DIG_OFF
                                              : NUM_DIGITS'(pol(8'(cur_onehot), ACTIVE_LOW));
        end
    end

    assign bus.seg_out    = seg_p1;
    assign bus.dig_sel    = dig_sel_p1;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_al ();

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Everything is derived from the number of clock edges since reset:
    // slot position, digit, completed frames and blink phase follow by division.
    function automatic logic [6:0] ref_decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input logic [15:0] sh, input int n,
                                           input logic lz, input logic [3:0] mask);
        int k;
        int frames;
        logic phase;
        k      = (n / SD) % N;
        frames = n / (SD * N);
        phase  = ((frames / BF) % 2) == 1;
        if (lz && k > 0 && (sh >> (4 * k)) == 16'd0) return 7'b0000000;
        if (mask[k] && phase) return 7'b0000000;
        return ref_decode(sh[4*k +: 4]);
    endfunction

    function automatic logic [3:0] ref_dig(input int n);
        if (n % SD == 0) return 4'b0000;
        return 4'(1 << ((n / SD) % N));
    endfunction

    function automatic logic ref_fd(input int n);
        return (n % (SD * N)) == (SD * N - 1);
    endfunction

    int          n_m;
    logic [15:0] sh_m;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_fd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_m     <= 0;
            sh_m    <= '0;
            exp_seg <= '0;
            exp_dig <= '0;
            exp_fd  <= 1'b0;
        end else begin
            exp_seg <= ref_seg(sh_m, n_m, bus.blank_lz, bus.blink_mask);
            exp_dig <= ref_dig(n_m);
            exp_fd  <= ref_fd(n_m);
            if (bus.load) sh_m <= bus.bcd_in;
            n_m <= n_m + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [15:0] bcd, input logic ld, input logic lz, input logic [3:0] mask);
        bus.bcd_in        = bcd;
        bus.load          = ld;
        bus.blank_lz      = lz;
        bus.blink_mask    = mask;
        bus_al.bcd_in     = bcd;
        bus_al.load       = ld;
        bus_al.blank_lz   = lz;
        bus_al.blink_mask = mask;
    endtask

    task automatic load_value(input logic [15:0] bcd, input logic lz, input logic [3:0] mask);
        drive(bcd, 1'b1, lz, mask);
        @(negedge clk);
        bus.load    = 1'b0;
        bus_al.load = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        n_cmp++; if (bus.seg_out !== 7'b0000000) begin n_bad++; $display("FAIL reset_seg: got %b want 0000000", bus.seg_out); end
        n_cmp++; if (bus.dig_sel !== 4'b0000) begin n_bad++; $display("FAIL reset_dig: got %b want 0000", bus.dig_sel); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        n_cmp++; if (bus_al.seg_out !== 7'b1111111) begin n_bad++; $display("FAIL reset_al_seg: got %b want 1111111", bus_al.seg_out); end
        n_cmp++; if (bus_al.dig_sel !== 4'b1111) begin n_bad++; $display("FAIL reset_al_dig: got %b want 1111", bus_al.dig_sel); end
        rst = 1'b0;
    endtask

    task automatic test_static_digits(input string name, input logic [15:0] bcd, input logic lz,
                                      input logic [6:0] w0, input logic [6:0] w1,
                                      input logic [6:0] w2, input logic [6:0] w3);
        logic [6:0] want [4];
        int pos;
        want[0] = w0; want[1] = w1; want[2] = w2; want[3] = w3;
        load_value(bcd, lz, 4'b0000);
        for (int c = 0; c < 32; c++) begin
            n_cmp++;
            if (bus.seg_out !== exp_seg || bus.dig_sel !== exp_dig || bus.frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL %s_model cyc %0d: got seg=%b dig=%b fd=%b want seg=%b dig=%b fd=%b",
                         name, c, bus.seg_out, bus.dig_sel, bus.frame_done, exp_seg, exp_dig, exp_fd);
            end
            case (bus.dig_sel)
                4'b0001: pos = 0;
                4'b0010: pos = 1;
                4'b0100: pos = 2;
                4'b1000: pos = 3;
                default: pos = -1;
            endcase
            if (pos >= 0) begin
                n_cmp++;
                if (bus.seg_out !== want[pos]) begin
                    n_bad++;
                    $display("FAIL %s_digit%0d: got %b want %b", name, pos, bus.seg_out, want[pos]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        int last;
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 16) begin n_bad++; $display("FAIL frame_spacing: got %0d want 16", c - last); end
                end
                last = c;
                pulses++;
            end
        end
        n_cmp++;
        if (pulses != 4) begin n_bad++; $display("FAIL frame_count: got %0d want 4", pulses); end
    endtask

    task automatic test_blink();
        int lit;
        int dark;
        lit  = 0;
        dark = 0;
        load_value(16'h5555, 1'b0, 4'b0100);
        for (int c = 0; c < 128; c++) begin
            n_cmp++;
            if (bus.seg_out !== exp_seg || bus.dig_sel !== exp_dig || bus.frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL blink_model cyc %0d: got seg=%b dig=%b want seg=%b dig=%b",
                         c, bus.seg_out, bus.dig_sel, exp_seg, exp_dig);
            end
            if (bus.dig_sel === 4'b0100) begin
                if (bus.seg_out === 7'b1011011) lit++;
                else if (bus.seg_out === 7'b0000000) dark++;
            end else if (bus.dig_sel !== 4'b0000) begin
                n_cmp++;
                if (bus.seg_out !== 7'b1011011) begin n_bad++; $display("FAIL blink_steady: got %b want 1011011", bus.seg_out); end
            end
            @(negedge clk);
        end
        n_cmp++; if (lit != 12) begin n_bad++; $display("FAIL blink_lit: got %0d want 12", lit); end
        n_cmp++; if (dark != 12) begin n_bad++; $display("FAIL blink_dark: got %0d want 12", dark); end
    endtask

    task automatic test_active_low();
        int dead;
        dead = 0;
        load_value(16'h0008, 1'b0, 4'b0000);
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (bus_al.seg_out !== ~exp_seg || bus_al.dig_sel !== ~exp_dig || bus_al.frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL al_model cyc %0d: got seg=%b dig=%b fd=%b want seg=%b dig=%b fd=%b",
                         c, bus_al.seg_out, bus_al.dig_sel, bus_al.frame_done, ~exp_seg, ~exp_dig, exp_fd);
            end
            if (bus_al.dig_sel === 4'b1110) begin
                n_cmp++;
                if (bus_al.seg_out !== 7'b0000000) begin n_bad++; $display("FAIL al_digit0: got %b want 0000000", bus_al.seg_out); end
            end
            if (bus_al.dig_sel === 4'b1111) dead++;
            @(negedge clk);
        end
        n_cmp++; if (dead != 4) begin n_bad++; $display("FAIL al_dead: got %0d want 4", dead); end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        load_value(16'h4321, 1'b1, 4'b0000);
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            if (bus.dig_sel === 4'b0100) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL arst_wait: got timeout want digit2 slot"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.seg_out !== 7'b0000000) begin n_bad++; $display("FAIL arst_seg: got %b want 0000000", bus.seg_out); end
        n_cmp++; if (bus.dig_sel !== 4'b0000) begin n_bad++; $display("FAIL arst_dig: got %b want 0000", bus.dig_sel); end
        n_cmp++; if (bus_al.seg_out !== 7'b1111111) begin n_bad++; $display("FAIL arst_al_seg: got %b want 1111111", bus_al.seg_out); end
        n_cmp++; if (bus_al.dig_sel !== 4'b1111) begin n_bad++; $display("FAIL arst_al_dig: got %b want 1111", bus_al.dig_sel); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.dig_sel !== 4'b0000) begin n_bad++; $display("FAIL arst_dead: got %b want 0000", bus.dig_sel); end
        n_cmp++; if (bus.seg_out !== 7'b1111110) begin n_bad++; $display("FAIL arst_dead_seg: got %b want 1111110", bus.seg_out); end
        @(negedge clk);
        n_cmp++; if (bus.dig_sel !== 4'b0001) begin n_bad++; $display("FAIL arst_first_dig: got %b want 0001", bus.dig_sel); end
        n_cmp++; if (bus.seg_out !== 7'b1111110) begin n_bad++; $display("FAIL arst_first_seg: got %b want 1111110", bus.seg_out); end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic        lz;
        logic [3:0]  mask;
        lz   = 1'b1;
        mask = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.seg_out !== exp_seg || bus.dig_sel !== exp_dig || bus.frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL rand_model cyc %0d: got seg=%b dig=%b fd=%b want seg=%b dig=%b fd=%b",
                         c, bus.seg_out, bus.dig_sel, bus.frame_done, exp_seg, exp_dig, exp_fd);
            end
            n_cmp++;
            if (bus_al.seg_out !== ~exp_seg || bus_al.dig_sel !== ~exp_dig) begin
                n_bad++;
                $display("FAIL rand_al cyc %0d: got seg=%b dig=%b want seg=%b dig=%b",
                         c, bus_al.seg_out, bus_al.dig_sel, ~exp_seg, ~exp_dig);
            end
            for (int d = 0; d < 4; d++) begin
                v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 31) == 0) lz = ~lz;
            if ($urandom_range(0, 47) == 0) mask = 4'($urandom_range(0, 15));
            drive(v, ($urandom_range(0, 7) == 0), lz, mask);
        end
        bus.load    = 1'b0;
        bus_al.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static_digits("scan1234", 16'h1234, 1'b0, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);
        test_frame_done();
        test_static_digits("lz0070", 16'h0070, 1'b1, 7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000);
        test_static_digits("lz0000", 16'h0000, 1'b1, 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000);
        test_static_digits("inv12A4", 16'h12A4, 1'b1, 7'b0110011, 7'b0000000, 7'b1101101, 7'b0110000);
        test_static_digits("zero_nolz", 16'h0000, 1'b0, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
        test_blink();
        test_active_low();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
